// File: rtl/uart_tx_top.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; line idles high.
// The baud counter, bit counter, shift register and frame FSM are all local to this module.
module uart_tx_top #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       tx_rst,
    input  logic       tx_en,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shift, shift_n;
    logic             tx_q, tx_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             bit_end;
    logic             accept;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign accept  = tx_en & tx_start;

    always_ff @(posedge clk) begin
        if (tx_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        tx_n    = tx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (accept) begin
                    state_n = START;
                    shift_n = data_in;
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end

            START: begin
                busy_n = 1'b1;
                if (bit_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                    tx_n    = shift[0];
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    busy_n = 1'b0;
                    done_n = 1'b1;
                    // A request seen on the stop-bit boundary starts the next frame on
                    // this same edge so held-high tx_start streams with no idle gap;
                    // busy rises one cycle later to keep it disjoint from done.
                    if (accept) begin
                        state_n = START;
                        shift_n = data_in;
                        bit_n   = '0;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top at 10 clocks per bit: frame table, directed corner sequences,
// and a random phase checked every cycle against a frame-timing reference model.
module tb_uart_tx_top;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       tx_rst, tx_en, tx_start;
    logic [7:0] data_in;
    logic       tx, busy, done;

    int nchk = 0;
    int nerr = 0;

    uart_tx_top #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk(clk), .tx_rst(tx_rst), .tx_en(tx_en), .tx_start(tx_start),
        .data_in(data_in), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a frame accepted at edge k puts line bit floor((e-k)/CPB) on tx
    // after edge e (start=0, data LSB first, stop=1) and reports done at edge k+10*CPB.
    function automatic logic line_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return d[idx-1];
    endfunction

    int         cyc = 0;
    int         m_k = 0;
    logic       m_act = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_fin, m_acc;
    logic       e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0;
    logic       mdl_on = 1'b0;

    always_comb begin
        m_fin = m_act && ((cyc - m_k) == 10 * CPB);
        m_acc = tx_en && tx_start && (!m_act || m_fin);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_rst) begin
            m_act  <= 1'b0;
            e_tx   <= 1'b1;
            e_busy <= 1'b0;
            e_done <= 1'b0;
        end else begin
            e_done <= m_fin;
            if (m_acc) begin
                m_act  <= 1'b1;
                m_k    <= cyc;
                m_data <= data_in;
                e_tx   <= 1'b0;
                e_busy <= !m_fin;
            end else if (m_fin || !m_act) begin
                m_act  <= 1'b0;
                e_tx   <= 1'b1;
                e_busy <= 1'b0;
            end else begin
                e_tx   <= line_bit(m_data, (cyc - m_k) / CPB);
                e_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk1("mdl_tx", tx, e_tx);
            chk1("mdl_busy", busy, e_busy);
            chk1("mdl_done", done, e_done);
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // frame[i] = line level during bit time i
        int         drop_en; // cycle after acceptance at which tx_en falls, -1 = never
    } vec_t;

    vec_t vecs[6];

    // Sends one frame from idle and checks every bit centre, busy and the done pulse.
    task automatic send_frame(input vec_t v);
        tx_en    = 1'b1;
        tx_start = 1'b1;
        data_in  = v.data;
        tick;
        tx_start = 1'b0;
        data_in  = ~v.data;
        for (int r = 0; r <= 101; r++) begin
            if (r > 0) tick;
            if (r == v.drop_en) tx_en = 1'b0;
            if (r == 0) chk1("frm_first_busy", busy, 1'b1);
            if (r % CPB == CPB / 2 && r < 10 * CPB) chk1("frm_bit", tx, v.frame[r / CPB]);
            if (r == 99) begin
                chk1("frm_busy_end", busy, 1'b1);
                chk1("frm_done_early", done, 1'b0);
            end
            if (r == 100) begin
                chk1("frm_done", done, 1'b1);
                chk1("frm_busy_off", busy, 1'b0);
                chk1("frm_idle_tx", tx, 1'b1);
            end
            if (r == 101) chk1("frm_done_one", done, 1'b0);
        end
        tx_en = 1'b1;
    endtask

    initial begin
        int dcnt;
        vecs[0] = '{8'hA5, 10'b1_1010_0101_0, -1};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0, -1};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0, -1};
        vecs[3] = '{8'h0F, 10'b1_0000_1111_0, -1};
        vecs[4] = '{8'h81, 10'b1_1000_0001_0, -1};
        vecs[5] = '{8'h55, 10'b1_0101_0101_0, 20};

        tx_rst = 1'b1; tx_en = 1'b0; tx_start = 1'b0; data_in = '0;
        repeat (3) begin
            tick;
            chk1("rst_tx", tx, 1'b1);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
        end
        tx_rst = 1'b0;
        mdl_on = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) send_frame(vecs[i]);

        // Request while busy is dropped, not queued.
        tx_en = 1'b1; tx_start = 1'b1; data_in = 8'h0F;
        tick;
        tx_start = 1'b0;
        dcnt = 0;
        for (int r = 0; r <= 120; r++) begin
            if (r > 0) tick;
            if (r == 35) begin tx_start = 1'b1; data_in = 8'hF0; end
            if (r == 36) tx_start = 1'b0;
            if (done) dcnt++;
            if (r % CPB == CPB / 2 && r < 10 * CPB) chk1("busy_bit", tx, vecs[3].frame[r / CPB]);
            if (r == 110 || r == 120) begin
                chk1("busy_after_tx", tx, 1'b1);
                chk1("busy_after_busy", busy, 1'b0);
            end
        end
        chkn("busy_done_cnt", dcnt, 1);

        // Reset mid-frame abandons it without done.
        tx_start = 1'b1; data_in = 8'hFF;
        tick;
        tx_start = 1'b0;
        repeat (47) tick;
        tx_rst = 1'b1;
        tick;
        tx_rst = 1'b0;
        chk1("mrst_tx", tx, 1'b1);
        chk1("mrst_busy", busy, 1'b0);
        dcnt = 0;
        repeat (110) begin
            tick;
            if (done) dcnt++;
        end
        chkn("mrst_done_cnt", dcnt, 0);
        send_frame(vecs[4]);

        // Disabled requests are ignored.
        tx_en = 1'b0; tx_start = 1'b1; data_in = 8'h55;
        tick;
        tx_start = 1'b0;
        for (int r = 0; r < 20; r++) begin
            tick;
            if (r == 0 || r == 19) begin
                chk1("en_off_tx", tx, 1'b1);
                chk1("en_off_busy", busy, 1'b0);
            end
        end
        send_frame(vecs[5]);

        // Held-high start streams frames back to back, re-sampling data_in.
        tx_en = 1'b1; tx_start = 1'b1; data_in = 8'h00;
        tick;
        for (int r = 0; r <= 205; r++) begin
            if (r > 0) tick;
            if (r == 50) data_in = 8'hFF;
            if (r == 150) tx_start = 1'b0;
            if (r % CPB == CPB / 2 && r < 10 * CPB) chk1("b2b_bit0", tx, vecs[1].frame[r / CPB]);
            if (r >= 100 && r < 200 && (r - 100) % CPB == CPB / 2)
                chk1("b2b_bit1", tx, vecs[2].frame[(r - 100) / CPB]);
            if (r == 100) begin
                chk1("b2b_start_tx", tx, 1'b0);
                chk1("b2b_done1", done, 1'b1);
                chk1("b2b_busy_gap", busy, 1'b0);
            end
            if (r == 101) chk1("b2b_busy_on", busy, 1'b1);
            if (r == 200) chk1("b2b_done2", done, 1'b1);
            if (r == 205) begin
                chk1("b2b_idle_tx", tx, 1'b1);
                chk1("b2b_idle_busy", busy, 1'b0);
            end
        end

        // Random traffic: the model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            tx_rst   = ($urandom_range(0, 399) == 0);
            tx_en    = ($urandom_range(0, 7) != 0);
            tx_start = ($urandom_range(0, 29) == 0) || (c % 700 < 250);
            data_in  = 8'($urandom);
            tick;
        end
        tx_rst = 1'b0; tx_start = 1'b0;
        repeat (120) tick;
        chk1("end_idle_tx", tx, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
